rect_pulse_gen_mc: RTL and testbench

Multi-channel rectangular pulse generator. All channels share one period counter; each channel has its own pulse width, amplitude and time offset. Configuration is double-buffered, so updates take effect only on a period boundary and never cause glitches. Supports continuous and triggered one-shot modes. Feeds the DAC/LED output stage in place of the fixed 4-tick, single-channel generator.

---
 rtl/rect_pulse_gen_mc_if.sv | 69 ++++++
 rtl/rect_pulse_gen_mc.sv | 223 ++++++++++++++++++++++
 tb/tb_rect_pulse_gen_mc.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rect_pulse_gen_mc_if.sv
// Interface bundling the control, configuration and status signals of the
// multi-channel rectangular pulse generator.
//
// Signals (master = controller side, slave = generator side):
//   en          run enable
//   mode        0 = continuous, 1 = one-shot
//   trig        one-shot start pulse (one clk wide)
//   div         prescaler, one tick every div+1 clocks
//   period      period length is period+1 ticks
//   width       per-channel high time, channel i at [i*CNT_W +: CNT_W]
//   amp         per-channel amplitude, channel i at [i*AMP_W +: AMP_W]
//   offset      per-channel delay from period start, channel i at [i*CNT_W +: CNT_W]
//   cfg_load    capture period/width/amp/offset into staging
//   out         per-channel output level
//   active      generator is running
//   period_tick one-clk pulse on the last tick of each period
//   cfg_pending staged configuration not yet applied
interface rect_pulse_gen_mc_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned AMP_W = 3,
    parameter int unsigned DIV_W = 16
);
    logic                    en;
    logic                    mode;
    logic                    trig;
    logic [DIV_W-1:0]        div;
    logic [CNT_W-1:0]        period;
    logic [N_CH*CNT_W-1:0]   width;
    logic [N_CH*AMP_W-1:0]   amp;
    logic [N_CH*CNT_W-1:0]   offset;
    logic                    cfg_load;
    logic [N_CH*AMP_W-1:0]   out;
    logic                    active;
    logic                    period_tick;
    logic                    cfg_pending;

    modport master (
        output en,
        output mode,
        output trig,
        output div,
        output period,
        output width,
        output amp,
        output offset,
        output cfg_load,
        input  out,
        input  active,
        input  period_tick,
        input  cfg_pending
    );

    modport slave (
        input  en,
        input  mode,
        input  trig,
        input  div,
        input  period,
        input  width,
        input  amp,
        input  offset,
        input  cfg_load,
        output out,
        output active,
        output period_tick,
        output cfg_pending
    );
endinterface

// File: rtl/rect_pulse_gen_mc.sv
// Multi-channel rectangular pulse generator.
//
// All channels share one prescaler and one period phase counter. Each channel
// has its own width, amplitude and offset. Configuration goes through a
// staging register (written by cfg_load) and a shadow register (used by the
// datapath); staging moves to shadow only while idle or on a period wrap, so
// a running waveform never sees a half-applied configuration.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset, released synchronously via armed_q
//   bus    rect_pulse_gen_mc_if slave modport (control, config, status)
module rect_pulse_gen_mc #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned AMP_W = 3,
    parameter int unsigned DIV_W = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    rect_pulse_gen_mc_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    // One-shot FSM and bookkeeping
    state_e                state_q, state_d;
    logic                  armed_q, armed_d;
    logic                  mode_q, mode_d;

    // Timebase
    logic [DIV_W-1:0]      psc_q, psc_d;
    logic [CNT_W-1:0]      phase_q, phase_d;

    // Staging configuration (written by cfg_load)
    logic [CNT_W-1:0]      st_period_q, st_period_d;
    logic [N_CH*CNT_W-1:0] st_width_q, st_width_d;
    logic [N_CH*AMP_W-1:0] st_amp_q, st_amp_d;
    logic [N_CH*CNT_W-1:0] st_offset_q, st_offset_d;

    // Shadow configuration (used by the datapath)
    logic [CNT_W-1:0]      sh_period_q, sh_period_d;
    logic [N_CH*CNT_W-1:0] sh_width_q, sh_width_d;
    logic [N_CH*AMP_W-1:0] sh_amp_q, sh_amp_d;
    logic [N_CH*CNT_W-1:0] sh_offset_q, sh_offset_d;

    logic                  pending_q, pending_d;
    logic [N_CH*AMP_W-1:0] out_q, out_d;

    logic active;
    logic mode_chg;
    logic run_on;
    logic tick;
    logic wrap;
    logic shot_end;
    logic apply;

    // Channel level for a given phase. d is the distance from the effective
    // offset, taken modulo the period length, in CNT_W+1 bits so that
    // period = 2**CNT_W - 1 cannot overflow.
    function automatic logic chan_high(
        input logic [CNT_W-1:0] ph,
        input logic [CNT_W-1:0] per,
        input logic [CNT_W-1:0] wid,
        input logic [CNT_W-1:0] off
    );
        logic [CNT_W:0]   p_len;
        logic [CNT_W:0]   d;
        logic [CNT_W-1:0] off_eff;
        p_len   = {1'b0, per} + (CNT_W+1)'(1);
        off_eff = (off > per) ? per : off;
        if (ph >= off_eff) begin
            d = {1'b0, ph} - {1'b0, off_eff};
        end else begin
            d = {1'b0, ph} + p_len - {1'b0, off_eff};
        end
        return d < {1'b0, wid};
    endfunction

    // Run status and timebase decode
    always_comb begin
        mode_chg = (bus.mode != mode_q);

        // armed_q holds the generator off for the first clk after reset release.
        active = 1'b0;
        if (armed_q) begin
            if (!bus.mode) begin
                active = bus.en;
            end else begin
                active = (state_q == StRun);
            end
        end

        // A mode change or en dropping during a one-shot run aborts this clk.
        run_on   = active && !mode_chg && bus.en;
        tick     = run_on && (psc_q == bus.div);
        wrap     = tick && (phase_q == sh_period_q);
        shot_end = wrap && bus.mode;
        apply    = pending_q && (!run_on || wrap);
    end

    // Prescaler and phase counter
    always_comb begin
        psc_d   = psc_q;
        phase_d = phase_q;
        if (!run_on) begin
            psc_d   = '0;
            phase_d = '0;
        end else begin
            psc_d = tick ? '0 : psc_q + DIV_W'(1);
            if (wrap) begin
                phase_d = '0;
            end else if (tick) begin
                phase_d = phase_q + CNT_W'(1);
            end
        end
    end

    // One-shot FSM; continuous mode keeps it parked in StIdle.
    always_comb begin
        state_d = state_q;
        armed_d = 1'b1;
        mode_d  = bus.mode;
        case (state_q)
            StIdle: begin
                if (armed_q && bus.mode && !mode_chg && bus.en && bus.trig) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!run_on || shot_end) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Configuration double buffering. When cfg_load coincides with a transfer,
    // the transfer takes the old staging values and the new ones stay pending.
    always_comb begin
        st_period_d = st_period_q;
        st_width_d  = st_width_q;
        st_amp_d    = st_amp_q;
        st_offset_d = st_offset_q;
        sh_period_d = sh_period_q;
        sh_width_d  = sh_width_q;
        sh_amp_d    = sh_amp_q;
        sh_offset_d = sh_offset_q;
        pending_d   = pending_q;

        if (apply) begin
            sh_period_d = st_period_q;
            sh_width_d  = st_width_q;
            sh_amp_d    = st_amp_q;
            sh_offset_d = st_offset_q;
            pending_d   = 1'b0;
        end
        if (bus.cfg_load) begin
            st_period_d = bus.period;
            st_width_d  = bus.width;
            st_amp_d    = bus.amp;
            st_offset_d = bus.offset;
            pending_d   = 1'b1;
        end
    end

    // Output levels, registered: out shows the phase of the previous clk.
    // The one-shot wrap clears out together with active.
    always_comb begin
        out_d = '0;
        if (run_on && !shot_end) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (chan_high(phase_q, sh_period_q, sh_width_q[i*CNT_W +: CNT_W],
                              sh_offset_q[i*CNT_W +: CNT_W])) begin
                    out_d[i*AMP_W +: AMP_W] = sh_amp_q[i*AMP_W +: AMP_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            armed_q     <= 1'b0;
            mode_q      <= 1'b0;
            psc_q       <= '0;
            phase_q     <= '0;
            st_period_q <= '0;
            st_width_q  <= '0;
            st_amp_q    <= '0;
            st_offset_q <= '0;
            sh_period_q <= '0;
            sh_width_q  <= '0;
            sh_amp_q    <= '0;
            sh_offset_q <= '0;
            pending_q   <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            mode_q      <= mode_d;
            psc_q       <= psc_d;
            phase_q     <= phase_d;
            st_period_q <= st_period_d;
            st_width_q  <= st_width_d;
            st_amp_q    <= st_amp_d;
            st_offset_q <= st_offset_d;
            sh_period_q <= sh_period_d;
            sh_width_q  <= sh_width_d;
            sh_amp_q    <= sh_amp_d;
            sh_offset_q <= sh_offset_d;
            pending_q   <= pending_d;
            out_q       <= out_d;
        end
    end

    assign bus.out         = out_q;
    assign bus.active      = active;
    assign bus.period_tick = wrap;
    assign bus.cfg_pending = pending_q;

endmodule

// File: tb/tb_rect_pulse_gen_mc.sv
module tb_rect_pulse_gen_mc;
    localparam int unsigned N_CH  = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned AMP_W = 3;
    localparam int unsigned DIV_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rect_pulse_gen_mc_if #(.N_CH(N_CH), .CNT_W(CNT_W), .AMP_W(AMP_W), .DIV_W(DIV_W)) bus ();

    rect_pulse_gen_mc #(.N_CH(N_CH), .CNT_W(CNT_W), .AMP_W(AMP_W), .DIV_W(DIV_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference configuration for the model
    int m_per;
    int m_w[N_CH];
    int m_a[N_CH];
    int m_o[N_CH];

    typedef struct {
        int          per;
        int          w;
        int          off;
        int          amp;
        logic [15:0] mask;   // bit p set = channel 0 high at phase p
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // High iff phase lies in the set {off_eff, off_eff+1, ...} of width
    // min(w, P) elements, taken modulo P.
    function automatic bit model_high(int phase, int per, int w, int off);
        int p  = per + 1;
        int oe = (off > per) ? per : off;
        int n  = (w < p) ? w : p;
        for (int j = 0; j < n; j++) begin
            if ((oe + j) % p == phase) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [N_CH*AMP_W-1:0] model_out(int phase);
        logic [N_CH*AMP_W-1:0] v = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (model_high(phase, m_per, m_w[i], m_o[i])) v[i*AMP_W +: AMP_W] = AMP_W'(m_a[i]);
        end
        return v;
    endfunction

    function automatic void clear_model();
        m_per = 0;
        for (int i = 0; i < N_CH; i++) begin
            m_w[i] = 0;
            m_a[i] = 0;
            m_o[i] = 0;
        end
    endfunction

    // Load the model config into the DUT while the generator is idle.
    task automatic load_cfg(input string tag);
        bus.period = CNT_W'(m_per);
        for (int i = 0; i < N_CH; i++) begin
            bus.width[i*CNT_W +: CNT_W]  = CNT_W'(m_w[i]);
            bus.amp[i*AMP_W +: AMP_W]    = AMP_W'(m_a[i]);
            bus.offset[i*CNT_W +: CNT_W] = CNT_W'(m_o[i]);
        end
        bus.cfg_load = 1'b1;
        @(negedge clk);
        bus.cfg_load = 1'b0;
        check($sformatf("%s pending_set", tag), 32'(bus.cfg_pending), 32'd1);
        @(negedge clk);
        check($sformatf("%s pending_clr", tag), 32'(bus.cfg_pending), 32'd0);
    endtask

    // Continuous run from phase 0; expectations from elapsed clk count.
    task automatic run_cont(input int div, input int nclk, input string tag);
        int d = div + 1;
        int p = m_per + 1;
        bus.div = DIV_W'(div);
        bus.en  = 1'b1;
        for (int k = 1; k <= nclk; k++) begin
            @(negedge clk);
            check($sformatf("%s out k=%0d", tag, k), 32'(bus.out), 32'(model_out(((k - 1) / d) % p)));
            check($sformatf("%s ptick k=%0d", tag, k), 32'(bus.period_tick),
                  32'((k % d == div) && ((k / d) % p == m_per)));
            check($sformatf("%s active k=%0d", tag, k), 32'(bus.active), 32'd1);
        end
        bus.en = 1'b0;
        @(negedge clk);
        check($sformatf("%s stop out", tag), 32'(bus.out), 32'd0);
        check($sformatf("%s stop active", tag), 32'(bus.active), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{per: 3, w: 2,   off: 0,  amp: 5, mask: 16'h0003};
        tbl[1] = '{per: 7, w: 3,   off: 6,  amp: 7, mask: 16'h00C1};
        tbl[2] = '{per: 9, w: 0,   off: 0,  amp: 3, mask: 16'h0000};
        tbl[3] = '{per: 9, w: 255, off: 0,  amp: 6, mask: 16'h03FF};
        tbl[4] = '{per: 9, w: 2,   off: 20, amp: 4, mask: 16'h0201};
        tbl[5] = '{per: 0, w: 1,   off: 0,  amp: 2, mask: 16'h0001};
        tbl[6] = '{per: 5, w: 3,   off: 4,  amp: 1, mask: 16'h0031};

        bus.en = 1'b0; bus.mode = 1'b0; bus.trig = 1'b0; bus.div = '0;
        bus.period = '0; bus.width = '0; bus.amp = '0; bus.offset = '0; bus.cfg_load = 1'b0;
        clear_model();

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst out", 32'(bus.out), 32'd0);
        check("rst active", 32'(bus.active), 32'd0);
        check("rst ptick", 32'(bus.period_tick), 32'd0);
        check("rst pending", 32'(bus.cfg_pending), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven single-channel patterns, div=0
        foreach (tbl[t]) begin
            int p;
            logic [15:0] mask;
            clear_model();
            m_per = tbl[t].per; m_w[0] = tbl[t].w; m_o[0] = tbl[t].off; m_a[0] = tbl[t].amp;
            p = m_per + 1;
            mask = tbl[t].mask;
            load_cfg($sformatf("tbl%0d", t));
            bus.div = '0;
            bus.en  = 1'b1;
            for (int k = 1; k <= 2 * p + 2; k++) begin
                @(negedge clk);
                check($sformatf("tbl%0d out k=%0d", t, k), 32'(bus.out),
                      mask[(k - 1) % p] ? 32'(tbl[t].amp) : 32'd0);
                check($sformatf("tbl%0d ptick k=%0d", t, k), 32'(bus.period_tick),
                      32'(k % p == m_per));
            end
            bus.en = 1'b0;
            @(negedge clk);
        end

        // Randomized multi-channel continuous runs
        for (int r = 0; r < 6; r++) begin
            int div;
            m_per = $urandom_range(0, 12);
            for (int i = 0; i < N_CH; i++) begin
                m_w[i] = $urandom_range(0, 15);
                m_o[i] = $urandom_range(0, 15);
                m_a[i] = $urandom_range(0, 7);
            end
            div = $urandom_range(0, 3);
            load_cfg($sformatf("rnd%0d", r));
            run_cont(div, 3 * (div + 1) * (m_per + 1) + 3, $sformatf("rnd%0d", r));
        end

        // Double buffering: width 2 -> 6 loaded at phase 1
        clear_model();
        m_per = 7; m_w[0] = 2; m_a[0] = 5;
        load_cfg("dbuf");
        bus.div = '0;
        bus.en  = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check($sformatf("dbuf out k=%0d", k), 32'(bus.out),
                  model_high((k - 1) % 8, 7, (k <= 8) ? 2 : 6, 0) ? 32'd5 : 32'd0);
            check($sformatf("dbuf pending k=%0d", k), 32'(bus.cfg_pending), 32'(k >= 2 && k <= 7));
            if (k == 1) begin
                bus.width[0 +: CNT_W] = CNT_W'(6);
                bus.cfg_load = 1'b1;
            end else begin
                bus.cfg_load = 1'b0;
            end
        end
        bus.en = 1'b0;
        @(negedge clk);

        // One-shot: period 4, second trig mid-run ignored
        clear_model();
        m_per = 4; m_w[0] = 2; m_a[0] = 5;
        load_cfg("shot");
        bus.mode = 1'b1;
        @(negedge clk); @(negedge clk);
        check("shot idle active", 32'(bus.active), 32'd0);
        bus.en = 1'b1;
        bus.trig = 1'b1;
        for (int s = 1; s <= 8; s++) begin
            @(negedge clk);
            check($sformatf("shot active s=%0d", s), 32'(bus.active), 32'(s <= 5));
            check($sformatf("shot out s=%0d", s), 32'(bus.out), (s == 2 || s == 3) ? 32'd5 : 32'd0);
            check($sformatf("shot ptick s=%0d", s), 32'(bus.period_tick), 32'(s == 5));
            bus.trig = (s == 3);
        end
        bus.en = 1'b0;
        bus.mode = 1'b0;
        @(negedge clk); @(negedge clk);

        // Mode change while running aborts
        bus.en = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("mchg pre active", 32'(bus.active), 32'd1);
        bus.mode = 1'b1;
        @(negedge clk);
        check("mchg out", 32'(bus.out), 32'd0);
        check("mchg active", 32'(bus.active), 32'd0);
        bus.en = 1'b0;
        bus.mode = 1'b0;
        @(negedge clk); @(negedge clk);

        // Prescaler div=2, reset asserted at phase 2
        clear_model();
        m_per = 7; m_w[0] = 3; m_a[0] = 7;
        load_cfg("psc");
        bus.div = DIV_W'(2);
        bus.en  = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("psc out k=%0d", k), 32'(bus.out), 32'(model_out(((k - 1) / 3) % 8)));
            check($sformatf("psc ptick k=%0d", k), 32'(bus.period_tick), 32'd0);
        end
        bus.cfg_load = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst out", 32'(bus.out), 32'd0);
        check("async rst active", 32'(bus.active), 32'd0);
        check("async rst pending", 32'(bus.cfg_pending), 32'd0);
        bus.cfg_load = 1'b0;
        bus.en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("post rst active %0d", k), 32'(bus.active), 32'd0);
            check($sformatf("post rst out %0d", k), 32'(bus.out), 32'd0);
        end
        bus.en = 1'b1;
        @(negedge clk);
        check("post rst en active", 32'(bus.active), 32'd1);
        @(negedge clk);
        check("post rst shadow clear out", 32'(bus.out), 32'd0);
        bus.en = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
